mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between InstCache (read-only) and DataCache (read/write).
//  Sits between both caches and the unified memory; replaces their private memory ports.
//  Round-robin arbitration, one transaction at a time, with a memory-ack watchdog.
// PARAMETERS
//  ADDR_W   32   byte address width, both requesters and memory
//  DATA_W   32   data/instruction width
//  TIMEOUT  255  max cycles in ISSUE awaiting mem_ack before abort (>=1)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  ic_req         in   1       icache read request, level; held until ic_valid
//  ic_addr        in   ADDR_W  icache fetch address
//  ic_valid       out  1       one-cycle pulse, ic_data valid
//  ic_data        out  DATA_W  fetched instruction
//  dc_rw_flag     in   2       00 idle, 01 read, 10 write, 11 treated as idle; held until done
//  dc_addr        in   ADDR_W  dcache address
//  dc_wdata       in   DATA_W  write data
//  dc_mask        in   4       byte-enable mask for writes
//  dc_free        out  1       arbiter in IDLE (accepting a new decision)
//  dc_read_valid  out  1       one-cycle pulse, dc_rdata valid
//  dc_rdata       out  DATA_W  read data
//  dc_write_done  out  1       one-cycle pulse, write committed
//  mem_req        out  1       memory request, level, high in ISSUE only
//  mem_we         out  1       1 = write
//  mem_addr       out  ADDR_W  registered address
//  mem_wdata      out  DATA_W  registered write data
//  mem_mask       out  4       registered byte mask (0000 on reads)
//  mem_ack        in   1       one-cycle completion from memory
//  mem_rdata      in   DATA_W  read data, valid with mem_ack
//  err_timeout    out  1       sticky: a transaction timed out
// BEHAVIOUR
//  Reset: state IDLE, owner=none, last=DC (icache wins first tie); all outputs 0 except dc_free=1.
//  States: IDLE -> ISSUE -> RESP -> IDLE.
//  IDLE: sample ic_req, dc_req=(dc_rw_flag==01|10). None: stay. One: grant it.
//   Both: grant the one != last. On grant latch owner, addr, we, wdata, mask;
//   set last=owner; go ISSUE. Decision cycle N -> mem_req high from N+1.
//  ISSUE: mem_req=1, outputs stable. mem_ack at cycle M: capture mem_rdata, go RESP.
//   mem_req low from M+1. Watchdog counts cycles in ISSUE; at TIMEOUT without ack:
//   set err_timeout, data=0, go RESP (owner still gets its completion pulse).
//  RESP (one cycle, M+1): pulse exactly one of ic_valid / dc_read_valid / dc_write_done
//   per owner/we; data output registered. Next state IDLE.
//   Requester must drop request by cycle M+2; IDLE at M+2 sees fresh requests only.
//  Min latency request->response pulse: 3 cycles (decision, issue with same-cycle... ack at N+1, pulse N+2).
//  Fairness: with both requesting continuously, grants strictly alternate; no starvation.
//  mem_ack outside ISSUE ignored. Request changes during ISSUE/RESP ignored (latched).
//  ic_data/dc_rdata hold last value between pulses; pulses never overlap.
//  Reset mid-transaction: IDLE next edge, mem_req=0, no completion pulse, err cleared;
//   late mem_ack after reset ignored.
//  dc_rw_flag==11 never granted. Watchdog counter width $clog2(TIMEOUT+1), cleared on entering ISSUE.
// TESTING
//  1 ic_req, addr 0x100, mem acks 2 cycles later with 0xDEADBEEF -> one ic_valid pulse, ic_data 0xDEADBEEF, mem_we 0.
//  2 dc write 0x200 data 0x12345678 mask 0011 -> mem_we 1, mem_mask 0011, one dc_write_done, no ic_valid.
//  3 both request from reset, held 4 transactions -> grant order IC,DC,IC,DC; mem_addr alternates.
//  4 no mem_ack with TIMEOUT=8 -> RESP after 8 ISSUE cycles, err_timeout=1 sticky, ic_data=0.
//  5 rst asserted mid-ISSUE, then mem_ack -> no response pulse, mem_req 0, dc_free 1, err_timeout 0.
//  6 dc_rw_flag=11 with ic idle -> stays IDLE, mem_req never asserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between the instruction cache
//                (read-only) and the data cache (read/write). Round-robin
//                arbitration, one transaction in flight, with a watchdog
//                that aborts a transaction if the memory never acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // instruction cache side
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_valid,
    output logic [DATA_W-1:0] ic_data,
    // data cache side
    input  logic [1:0]        dc_rw_flag,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic [3:0]        dc_mask,
    output logic              dc_free,
    output logic              dc_read_valid,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_write_done,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              err_timeout
);

    localparam int              C_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT - 1);
    localparam logic [C_WD_W-1:0] C_WD_ONE  = C_WD_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner_dc;   // 1 = data cache owns the current transaction
    logic              r_last_dc;    // 1 = data cache received the most recent grant
    logic [C_WD_W-1:0] r_wd;         // cycles spent in ISSUE so far

    logic              w_dc_req;
    logic              w_dc_write;
    logic              w_grant_dc;
    logic              w_any_req;
    logic              w_finish;
    logic [DATA_W-1:0] w_resp_data;

    // Request decode and round-robin choice: on a tie the side that was not served last wins
    always_comb begin
        w_dc_req    = (dc_rw_flag == 2'b01) || (dc_rw_flag == 2'b10);
        w_dc_write  = (dc_rw_flag == 2'b10);
        w_any_req   = ic_req || w_dc_req;
        w_grant_dc  = w_dc_req && (!ic_req || !r_last_dc);
        w_finish    = mem_ack || (r_wd == C_WD_LAST);
        w_resp_data = mem_ack ? mem_rdata : '0;
    end

    // Transaction sequencer: IDLE -> ISSUE -> RESP -> IDLE, all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_owner_dc    <= 1'b0;
            r_last_dc     <= 1'b1;
            r_wd          <= '0;
            ic_valid      <= 1'b0;
            ic_data       <= '0;
            dc_free       <= 1'b1;
            dc_read_valid <= 1'b0;
            dc_rdata      <= '0;
            dc_write_done <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_mask      <= 4'b0000;
            err_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_dc <= w_grant_dc;
                        r_last_dc  <= w_grant_dc;
                        r_wd       <= '0;
                        mem_req    <= 1'b1;
                        dc_free    <= 1'b0;
                        mem_we     <= w_grant_dc && w_dc_write;
                        mem_addr   <= w_grant_dc ? dc_addr : ic_addr;
                        mem_wdata  <= (w_grant_dc && w_dc_write) ? dc_wdata : '0;
                        mem_mask   <= (w_grant_dc && w_dc_write) ? dc_mask : 4'b0000;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_finish) begin
                        // An ack on the final watchdog cycle still counts as a success
                        mem_req <= 1'b0;
                        r_state <= S_RESP;
                        if (!mem_ack) begin
                            err_timeout <= 1'b1;
                        end
                        if (!r_owner_dc) begin
                            ic_valid <= 1'b1;
                            ic_data  <= w_resp_data;
                        end else if (mem_we) begin
                            dc_write_done <= 1'b1;
                        end else begin
                            dc_read_valid <= 1'b1;
                            dc_rdata      <= w_resp_data;
                        end
                    end else begin
                        r_wd <= r_wd + C_WD_ONE;
                    end
                end
                S_RESP: begin
                    ic_valid      <= 1'b0;
                    dc_read_valid <= 1'b0;
                    dc_write_done <= 1'b0;
                    dc_free       <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    ic_valid      <= 1'b0;
                    dc_read_valid <= 1'b0;
                    dc_write_done <= 1'b0;
                    mem_req       <= 1'b0;
                    dc_free       <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Acts as both caches
//                and the memory; predicts grants, completions, data and the
//                sticky timeout flag at transaction level.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int C_TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic [1:0]  dc_rw_flag;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_mask;
    logic        dc_free;
    logic        dc_read_valid;
    logic [31:0] dc_rdata;
    logic        dc_write_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: who was served last, expected data registers, sticky error
    logic        exp_last_dc;
    logic [31:0] exp_ic_data;
    logic [31:0] exp_dc_rdata;
    logic        exp_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(C_TO)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ic_req       (ic_req),
        .ic_addr      (ic_addr),
        .ic_valid     (ic_valid),
        .ic_data      (ic_data),
        .dc_rw_flag   (dc_rw_flag),
        .dc_addr      (dc_addr),
        .dc_wdata     (dc_wdata),
        .dc_mask      (dc_mask),
        .dc_free      (dc_free),
        .dc_read_valid(dc_read_valid),
        .dc_rdata     (dc_rdata),
        .dc_write_done(dc_write_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_mask     (mem_mask),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .err_timeout  (err_timeout)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pulses();
        return {29'd0, ic_valid, dc_read_valid, dc_write_done};
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_last_dc  = 1'b1;
        exp_ic_data  = '0;
        exp_dc_rdata = '0;
        exp_err      = 1'b0;
    endtask

    // One complete transaction, entered and left at a negedge with the DUT idle.
    // d = ISSUE cycles without ack before the ack arrives; d >= C_TO means no ack.
    task automatic do_txn(input logic ic, input logic [31:0] ia, input logic [1:0] fl,
                          input logic [31:0] da, input logic [31:0] wd, input logic [3:0] mk,
                          input int d, input logic [31:0] rd);
        logic        want_dc;
        logic        win_dc;
        logic        wr;
        logic        acked;
        logic [31:0] resp;
        logic [31:0] exp_p;
        ic_req     = ic;
        ic_addr    = ia;
        dc_rw_flag = fl;
        dc_addr    = da;
        dc_wdata   = wd;
        dc_mask    = mk;
        want_dc    = (fl == 2'b01) || (fl == 2'b10);
        if (!ic && !want_dc) begin
            // Nothing grantable: memory acks here must be ignored
            for (int k = 0; k < 3; k++) begin
                mem_ack   = k[0];
                mem_rdata = $urandom;
                @(negedge clk);
                check_val("idle_mem_req", {31'd0, mem_req}, 32'd0);
                check_val("idle_free", {31'd0, dc_free}, 32'd1);
                check_val("idle_pulses", pulses(), 32'd0);
            end
            mem_ack    = 1'b0;
            dc_rw_flag = 2'b00;
            return;
        end
        win_dc      = want_dc && (!ic || !exp_last_dc);
        exp_last_dc = win_dc;
        wr          = win_dc && (fl == 2'b10);
        acked       = 1'b0;
        @(negedge clk);
        for (int k = 0; k < C_TO; k++) begin
            check_val("iss_mem_req", {31'd0, mem_req}, 32'd1);
            check_val("iss_free", {31'd0, dc_free}, 32'd0);
            check_val("iss_pulses", pulses(), 32'd0);
            check_val("iss_addr", mem_addr, win_dc ? da : ia);
            check_val("iss_we", {31'd0, mem_we}, {31'd0, wr});
            check_val("iss_mask", {28'd0, mem_mask}, wr ? {28'd0, mk} : 32'd0);
            if (wr) check_val("iss_wdata", mem_wdata, wd);
            if (k == d) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
                acked     = 1'b1;
            end else begin
                mem_rdata = $urandom;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (acked) break;
        end
        resp = acked ? rd : 32'd0;
        if (!acked) exp_err = 1'b1;
        exp_p = !win_dc ? 32'd4 : (wr ? 32'd1 : 32'd2);
        if (!win_dc) exp_ic_data = resp;
        else if (!wr) exp_dc_rdata = resp;
        check_val("resp_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("resp_pulses", pulses(), exp_p);
        check_val("resp_ic_data", ic_data, exp_ic_data);
        check_val("resp_dc_rdata", dc_rdata, exp_dc_rdata);
        check_val("resp_err", {31'd0, err_timeout}, {31'd0, exp_err});
        ic_req     = 1'b0;
        dc_rw_flag = 2'b00;
        mem_ack    = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("post_free", {31'd0, dc_free}, 32'd1);
        check_val("post_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("post_pulses", pulses(), 32'd0);
        check_val("post_err", {31'd0, err_timeout}, {31'd0, exp_err});
    endtask

    initial begin
        rst        = 1'b1;
        ic_req     = 1'b0;
        ic_addr    = '0;
        dc_rw_flag = 2'b00;
        dc_addr    = '0;
        dc_wdata   = '0;
        dc_mask    = 4'b0000;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        apply_reset();

        check_val("rst_free", {31'd0, dc_free}, 32'd1);
        check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_pulses", pulses(), 32'd0);
        check_val("rst_err", {31'd0, err_timeout}, 32'd0);
        check_val("rst_ic_data", ic_data, 32'd0);

        // Both requesting from reset: IC, DC, IC, DC
        for (int i = 0; i < 4; i++)
            do_txn(1'b1, 32'h1000 + 32'(i), 2'b01, 32'h2000 + 32'(i), 32'h0, 4'hF, 1, $urandom);

        // Single icache fetch, ack two cycles into ISSUE
        do_txn(1'b1, 32'h100, 2'b00, 32'h0, 32'h0, 4'h0, 1, 32'hDEADBEEF);
        // Data cache partial write
        do_txn(1'b0, 32'h0, 2'b10, 32'h200, 32'h12345678, 4'b0011, 0, 32'hCAFEF00D);
        // Flag 11 is never granted
        do_txn(1'b0, 32'h0, 2'b11, 32'h300, 32'h0, 4'h0, 0, 32'h0);
        // Watchdog abort on an icache fetch
        do_txn(1'b1, 32'h400, 2'b00, 32'h0, 32'h0, 4'h0, C_TO + 5, 32'h0);

        for (int i = 0; i < 200; i++)
            do_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom,
                   $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 9)), $urandom);

        // Reset in the middle of ISSUE, followed by a late ack
        ic_req  = 1'b1;
        ic_addr = 32'h500;
        @(negedge clk);
        check_val("mid_mem_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        ic_req       = 1'b0;
        mem_ack      = 1'b1;
        mem_rdata    = 32'h55AA55AA;
        exp_last_dc  = 1'b1;
        exp_ic_data  = '0;
        exp_dc_rdata = '0;
        exp_err      = 1'b0;
        check_val("mrst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("mrst_free", {31'd0, dc_free}, 32'd1);
        check_val("mrst_err", {31'd0, err_timeout}, 32'd0);
        check_val("mrst_pulses", pulses(), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("late_ack_pulses", pulses(), 32'd0);
        check_val("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("late_ack_ic_data", ic_data, 32'd0);

        // After reset the icache wins the first tie again
        do_txn(1'b1, 32'h600, 2'b10, 32'h700, 32'h11112222, 4'hF, 2, 32'h33334444);
        do_txn(1'b1, 32'h604, 2'b10, 32'h704, 32'h55556666, 4'h3, 0, 32'h77778888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
